dmem_ctrl: RTL and testbench

Parametrised data memory for the single-cycle/multi-cycle CPU datapath. It replaces the fixed 32-word, flag-driven data memory with a configurable-depth, byte-addressed, little-endian memory that has a req/ready request port, a registered one-cycle response and misalignment fault reporting. An optional post-reset clear sequencer zeroes the array before the first request is accepted. It sits between the execute stage (address/store data) and the write-back mux (load data).

---
 rtl/dmem_ctrl.sv | 158 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Byte-addressed little-endian data memory with req/ready port, registered response and fault count.
// Define DMEM_CLEAR_EN to zero the whole array after reset before the first request is accepted.
module dmem_ctrl #(
  parameter int ADDR_W = 12,
  parameter int FCNT_W = 8
) (
  input  logic              dm_clk,
  input  logic              dm_rst_n,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_size,
  input  logic              dm_unsigned,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_ready,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,
  output logic              dm_fault,
  output logic [FCNT_W-1:0] dm_fault_cnt
);

  // state    | meaning
  // ST_CLEAR | zeroing one word per cycle, requests refused
  // ST_PEND  | one-cycle hold after reset release, requests refused
  // ST_RUN   | accepting one request per cycle
  typedef enum logic [1:0] {ST_CLEAR, ST_PEND, ST_RUN} state_e;

  localparam int WIDX_W = ADDR_W - 2;
  localparam int DEPTH  = 1 << WIDX_W;
`ifdef DMEM_CLEAR_EN
  localparam state_e ST_RST = ST_CLEAR;
`else
  localparam state_e ST_RST = ST_PEND;
`endif

  state_e state_q, state_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
`ifdef DMEM_CLEAR_EN
  logic [WIDX_W-1:0] clr_cnt_q, clr_cnt_d;
`endif

  logic [31:0]       mem [DEPTH];
  logic [WIDX_W-1:0] widx;
  logic [1:0]        lane;
  logic              accept, req_fault;
  logic [31:0]       rword, rshift, ld_data;
  logic              mem_we;
  logic [WIDX_W-1:0] mem_idx;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;

  always_comb begin
    widx   = dm_addr[ADDR_W-1:2];
    lane   = dm_addr[1:0];
    accept = dm_req && (state_q == ST_RUN);

    case (dm_size)
      2'b00:   req_fault = 1'b0;
      2'b01:   req_fault = dm_addr[0];
      2'b10:   req_fault = |dm_addr[1:0];
      default: req_fault = 1'b1;
    endcase

    rword  = mem[widx];
    rshift = rword >> {lane, 3'b000};
    case (dm_size)
      2'b00:   ld_data = dm_unsigned ? {24'b0, rshift[7:0]}  : {{24{rshift[7]}}, rshift[7:0]};
      2'b01:   ld_data = dm_unsigned ? {16'b0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      default: ld_data = rword;
    endcase

    // Store data is replicated across lanes so the byte enables alone pick the target lanes.
    mem_we  = accept && dm_we && !req_fault;
    mem_idx = widx;
    case (dm_size)
      2'b00: begin
        mem_be    = 4'b0001 << lane;
        mem_wdata = {4{dm_wdata[7:0]}};
      end
      2'b01: begin
        mem_be    = 4'b0011 << lane;
        mem_wdata = {2{dm_wdata[15:0]}};
      end
      default: begin
        mem_be    = 4'b1111;
        mem_wdata = dm_wdata;
      end
    endcase

    state_d = state_q;
`ifdef DMEM_CLEAR_EN
    clr_cnt_d = clr_cnt_q;
`endif
    case (state_q)
      ST_CLEAR: begin
`ifdef DMEM_CLEAR_EN
        mem_we    = 1'b1;
        mem_idx   = clr_cnt_q;
        mem_be    = 4'b1111;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == {WIDX_W{1'b1}}) state_d = ST_RUN;
`else
        state_d = ST_RUN;
`endif
      end
      ST_PEND: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase

    rvalid_d = accept;
    fault_d  = accept && req_fault;
    rdata_d  = (accept && !dm_we && !req_fault) ? ld_data : 32'b0;
    fcnt_d   = fcnt_q;
    if (accept && req_fault && (fcnt_q != {FCNT_W{1'b1}})) fcnt_d = fcnt_q + 1'b1;
  end

  always_ff @(posedge dm_clk or negedge dm_rst_n) begin
    if (!dm_rst_n) begin
      state_q  <= ST_RST;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
      fcnt_q   <= '0;
`ifdef DMEM_CLEAR_EN
      clr_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
      fcnt_q   <= fcnt_d;
`ifdef DMEM_CLEAR_EN
      clr_cnt_q <= clr_cnt_d;
`endif
    end
  end

  // The array is deliberately left out of reset.
  always_ff @(posedge dm_clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  assign dm_ready     = (state_q == ST_RUN);
  assign dm_rvalid    = rvalid_q;
  assign dm_rdata     = rdata_q;
  assign dm_fault     = fault_q;
  assign dm_fault_cnt = fcnt_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios plus random traffic against a byte-array reference model.
// Build with or without DMEM_CLEAR_EN to match the design under test.
module tb_dmem_ctrl;

  localparam int NBYTES = 4096;
`ifdef DMEM_CLEAR_EN
  localparam int EXP_CLR = 1024;
`else
  localparam int EXP_CLR = 1;
`endif

  logic        dm_clk = 1'b0;
  logic        dm_rst_n;
  logic        dm_req, dm_we, dm_unsigned;
  logic [1:0]  dm_size;
  logic [11:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ready, dm_rvalid, dm_fault;
  logic [31:0] dm_rdata;
  logic [7:0]  dm_fault_cnt;

  logic        s_req;
  logic [1:0]  s_size;
  logic        s_ready, s_rvalid, s_fault;
  logic [31:0] s_rdata;
  logic [1:0]  s_fcnt;

  always #5 dm_clk = ~dm_clk;

  dmem_ctrl #(.ADDR_W(12), .FCNT_W(8)) u_dut (
    .dm_clk(dm_clk), .dm_rst_n(dm_rst_n), .dm_req(dm_req), .dm_we(dm_we),
    .dm_size(dm_size), .dm_unsigned(dm_unsigned), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_fault(dm_fault),
    .dm_fault_cnt(dm_fault_cnt)
  );

  dmem_ctrl #(.ADDR_W(4), .FCNT_W(2)) u_sat (
    .dm_clk(dm_clk), .dm_rst_n(dm_rst_n), .dm_req(s_req), .dm_we(1'b0),
    .dm_size(s_size), .dm_unsigned(1'b0), .dm_addr(4'h0), .dm_wdata(32'h0),
    .dm_ready(s_ready), .dm_rvalid(s_rvalid), .dm_rdata(s_rdata), .dm_fault(s_fault),
    .dm_fault_cnt(s_fcnt)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  mem_m [NBYTES];
  int          fcnt_m;
  bit          ready_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_load(input int a, input int sz, input bit uns);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mem_m[a + i]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic m_store(input int a, input int sz, input logic [31:0] wd);
    for (int i = 0; i < (1 << sz); i++) mem_m[a + i] = 8'(wd >> (8 * i));
  endtask

  task automatic m_zero();
    for (int i = 0; i < NBYTES; i++) mem_m[i] = 8'h00;
  endtask

  // One request cycle; the response is checked one edge later against the model.
  task automatic step(input bit req, input bit we, input int sz, input bit uns,
                      input int addr, input logic [31:0] wd);
    bit acc, flt;
    logic [31:0] exp_rd;
    @(negedge dm_clk);
    dm_req = req; dm_we = we; dm_size = 2'(sz); dm_unsigned = uns;
    dm_addr = 12'(addr); dm_wdata = wd;
    acc = req && ready_m;
    flt = acc && (sz == 3 || (addr % (1 << sz)) != 0);
    exp_rd = 32'h0;
    if (acc && !flt) begin
      if (we) m_store(addr, sz, wd);
      else exp_rd = m_load(addr, sz, uns);
    end
    if (flt && fcnt_m < 255) fcnt_m++;
    @(posedge dm_clk); #1;
    chk("rvalid", dm_rvalid, 32'(acc));
    chk("rdata", dm_rdata, exp_rd);
    chk("fault", dm_fault, 32'(flt));
    chk("fault_cnt", dm_fault_cnt, 32'(fcnt_m));
    chk("ready", dm_ready, 32'(ready_m));
  endtask

  task automatic release_and_measure();
    int cnt;
    bit saw_rv;
    cnt = 0;
    saw_rv = 1'b0;
    @(negedge dm_clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'd2; dm_addr = 12'h0;
    dm_rst_n = 1'b1;
    while (cnt < 5000) begin
      @(posedge dm_clk); #1;
      cnt++;
      if (dm_rvalid !== 1'b0) saw_rv = 1'b1;
      if (dm_ready === 1'b1) break;
    end
    chk("clear_len", 32'(cnt), 32'(EXP_CLR));
    chk("clear_no_resp", 32'(saw_rv), 32'h0);
    fcnt_m = 0;
    ready_m = 1'b1;
`ifdef DMEM_CLEAR_EN
    m_zero();
`endif
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, dm_ready, 32'h0);
    chk({tag, "_rvalid"}, dm_rvalid, 32'h0);
    chk({tag, "_rdata"}, dm_rdata, 32'h0);
    chk({tag, "_fault"}, dm_fault, 32'h0);
    chk({tag, "_fcnt"}, dm_fault_cnt, 32'h0);
  endtask

  initial begin
    dm_req = 0; dm_we = 0; dm_size = 0; dm_unsigned = 0; dm_addr = 0; dm_wdata = 0;
    s_req = 0; s_size = 2'd3;
    fcnt_m = 0; ready_m = 1'b0;
    m_zero();
    dm_rst_n = 1'b1;
    #1 dm_rst_n = 1'b0;
    #1 chk_reset_outputs("rst");
    #20;
    release_and_measure();

`ifndef DMEM_CLEAR_EN
    for (int w = 0; w < NBYTES / 4; w++) step(1, 1, 2, 0, w * 4, 32'h0);
`endif

    step(1, 0, 2, 0, 12'h3FC, 0);
    chk("clr_3fc", dm_rdata, 32'h0);
    step(1, 0, 2, 0, 12'hFFC, 0);

    step(1, 1, 2, 0, 12'h010, 32'h80FF7F01);
    step(1, 0, 0, 1, 12'h011, 0);
    chk("lbu_11", dm_rdata, 32'h0000007F);
    step(1, 0, 0, 1, 12'h012, 0);
    chk("lbu_12", dm_rdata, 32'h000000FF);
    step(1, 0, 0, 1, 12'h013, 0);
    chk("lbu_13", dm_rdata, 32'h00000080);
    step(1, 0, 0, 0, 12'h013, 0);
    chk("lb_13", dm_rdata, 32'hFFFFFF80);

    step(1, 1, 2, 0, 12'h020, 32'h11223344);
    step(1, 1, 1, 0, 12'h022, 32'h0000BEEF);
    step(1, 0, 2, 0, 12'h020, 0);
    chk("lw_20", dm_rdata, 32'hBEEF3344);
    step(1, 0, 1, 0, 12'h022, 0);
    chk("lh_22", dm_rdata, 32'hFFFFBEEF);

    step(1, 1, 2, 0, 12'h030, 32'h0);
    step(1, 1, 0, 0, 12'h031, 32'h123456AA);
    step(1, 0, 2, 0, 12'h030, 0);
    chk("b2b_30", dm_rdata, 32'h0000AA00);
    step(0, 0, 0, 0, 0, 0);

    step(1, 1, 2, 0, 12'h040, 32'hCAFEF00D);
    step(1, 1, 1, 0, 12'h041, 32'h00001111);
    step(1, 1, 2, 0, 12'h042, 32'h22222222);
    step(1, 0, 3, 0, 12'h040, 0);
    chk("fcnt_3", dm_fault_cnt, 32'd3);
    step(1, 0, 2, 0, 12'h040, 0);
    chk("unchanged_40", dm_rdata, 32'hCAFEF00D);

    for (int k = 0; k < 400; k++) begin
      int sz;
      sz = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      step($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1,
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NBYTES - 1)) : int'($urandom_range(0, 127)),
           $urandom);
    end

    step(1, 1, 2, 0, 12'h3FC, 32'hA5A5A5A5);
    step(1, 0, 2, 0, 12'h010, 0);
    #2 dm_rst_n = 1'b0;
    ready_m = 1'b0;
    #1 chk_reset_outputs("rst_inflight");
    release_and_measure();
    step(1, 0, 2, 0, 12'h010, 0);
    step(1, 0, 2, 0, 12'h3FC, 0);

`ifdef DMEM_CLEAR_EN
    step(1, 1, 2, 0, 12'h3FC, 32'h5A5A5A5A);
    @(negedge dm_clk);
    dm_rst_n = 1'b0;
    ready_m = 1'b0;
    dm_req = 1'b0;
    @(negedge dm_clk);
    dm_rst_n = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(posedge dm_clk); #1;
    end
    chk("midclr_ready", dm_ready, 32'h0);
    #2 dm_rst_n = 1'b0;
    #1 chk_reset_outputs("rst_midclr");
    release_and_measure();
    step(1, 0, 2, 0, 12'h3FC, 0);
    chk("midclr_3fc", dm_rdata, 32'h0);
    step(1, 0, 2, 0, 12'hFFC, 0);
`endif

    step(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge dm_clk);
      s_req = 1'b1;
      @(posedge dm_clk); #1;
      chk("sat_rvalid", s_rvalid, 32'h1);
      chk("sat_fault", s_fault, 32'h1);
      chk("sat_cnt", s_fcnt, 32'((k < 3) ? k : 3));
    end
    @(negedge dm_clk);
    s_req = 1'b0;
    @(posedge dm_clk); #1;
    chk("sat_idle_rvalid", s_rvalid, 32'h0);
    chk("sat_hold", s_fcnt, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
